// File: rtl/axi_mem_sram_bank_if.sv
// ----------------------------------------------------------------------------
// axi_mem_sram_bank_if
//   Request/response bundle between the AXI-to-memory adapter and the SRAM
//   bank. Signal names keep the adapter's _i/_o naming as seen from the bank.
//
//   Request  (adapter -> bank): req_i, we_i, addr_i, be_i, data_i, user_i
//   Response (bank -> adapter): data_o, user_o, ready_o, oor_o
//
//   modport master : the adapter side (drives requests)
//   modport slave  : the memory bank side (drives responses)
// ----------------------------------------------------------------------------
interface axi_mem_sram_bank_if #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 10
);
  logic                    req_i;
  logic                    we_i;
  logic [ADDR_WIDTH-1:0]   addr_i;
  logic [DATA_WIDTH/8-1:0] be_i;
  logic [DATA_WIDTH-1:0]   data_i;
  logic [USER_WIDTH-1:0]   user_i;
  logic [DATA_WIDTH-1:0]   data_o;
  logic [USER_WIDTH-1:0]   user_o;
  logic                    ready_o;
  logic                    oor_o;

  modport master (
    output req_i, we_i, addr_i, be_i, data_i, user_i,
    input  data_o, user_o, ready_o, oor_o
  );

  modport slave (
    input  req_i, we_i, addr_i, be_i, data_i, user_i,
    output data_o, user_o, ready_o, oor_o
  );
endinterface

// File: rtl/axi_mem_sram_bank.sv
// ----------------------------------------------------------------------------
// axi_mem_sram_bank
//   Word-organised on-chip storage placed directly behind the AXI-to-memory
//   adapter. Reads return data and user bits one cycle after the request.
//   After reset an optional sequencer zero-fills every word (one per cycle)
//   before requests are accepted. Out-of-range requests are flagged with a
//   one-cycle pulse; serviced reads and writes are counted.
//
//   Ports:
//     clk_i     clock
//     rst_i     asynchronous, active-high reset
//     bus       slave side of axi_mem_sram_bank_if (request in, response out)
//     rd_cnt_o  number of serviced reads  (wraps)
//     wr_cnt_o  number of serviced writes (wraps)
// ----------------------------------------------------------------------------
module axi_mem_sram_bank #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 10,
  parameter int unsigned NUM_WORDS  = 1024,
  parameter bit          INIT_ZERO  = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  axi_mem_sram_bank_if.slave      bus,
  output logic [31:0]             rd_cnt_o,
  output logic [31:0]             wr_cnt_o
);

  localparam int unsigned NB = DATA_WIDTH / 8;      // bytes per word
  localparam int unsigned LB = $clog2(NB);          // byte-offset bits
  localparam int unsigned IW = $clog2(NUM_WORDS);   // word-index bits

  localparam logic [IW:0] FILL_LAST = (IW+1)'(NUM_WORDS - 1);
  localparam logic [IW:0] FILL_ONE  = (IW+1)'(1);

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_e;

  localparam state_e RESET_STATE = INIT_ZERO ? ST_INIT : ST_READY;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q      [NUM_WORDS];
  logic [USER_WIDTH-1:0] user_mem_q [NUM_WORDS];

  // --------------------------------------------------------------------------
  // Control state and registered outputs
  // --------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [IW:0]           fill_q;
  logic                  ready_q;
  logic                  oor_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [USER_WIDTH-1:0] user_q;
  logic [31:0]           rd_cnt_q;
  logic [31:0]           wr_cnt_q;

  // Write port shared between the zero-fill sequencer and normal writes.
  logic                  mem_we;
  logic [IW-1:0]         mem_idx;
  logic [NB-1:0]         mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [USER_WIDTH-1:0] mem_wuser;

  // Request classification for the current cycle.
  logic                  svc_rd;
  logic                  svc_wr;
  logic                  svc_oor;

  // --------------------------------------------------------------------------
  // Address decode: index = addr >> LB; anything above the index bits must be
  // zero for the request to hit a word. Byte-offset bits are don't-care.
  // --------------------------------------------------------------------------
  logic [IW-1:0] req_idx;
  logic          in_range;

  assign req_idx  = bus.addr_i[LB+IW-1:LB];
  assign in_range = (bus.addr_i[ADDR_WIDTH-1:LB+IW] == '0);

  logic unused_addr_bits;
  if (LB > 0) begin : g_offset
    assign unused_addr_bits = ^bus.addr_i[(LB > 0 ? LB-1 : 0):0];
  end else begin : g_no_offset
    assign unused_addr_bits = 1'b0;
  end

  // --------------------------------------------------------------------------
  // Next-state and write-port steering
  // --------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    mem_idx   = req_idx;
    mem_be    = bus.be_i;
    mem_wdata = bus.data_i;
    mem_wuser = bus.user_i;
    svc_rd    = 1'b0;
    svc_wr    = 1'b0;
    svc_oor   = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        // Requests are ignored; the sequencer owns the write port.
        mem_we    = 1'b1;
        mem_idx   = fill_q[IW-1:0];
        mem_be    = '1;
        mem_wdata = '0;
        mem_wuser = '0;
        if (fill_q == FILL_LAST) begin
          state_d = ST_READY;
        end
      end

      ST_READY: begin
        if (bus.req_i) begin
          if (!in_range) begin
            svc_oor = 1'b1;
          end else if (bus.we_i) begin
            svc_wr = 1'b1;
            mem_we = 1'b1;
          end else begin
            svc_rd = 1'b1;
          end
        end
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register, fill counter, read data path and counters
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of block ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= RESET_STATE;
      fill_q   <= '0;
      ready_q  <= 1'b0;
      oor_q    <= 1'b0;
      data_q   <= '0;
      user_q   <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ST_READY);
      oor_q   <= svc_oor;

      if (state_q == ST_INIT) begin
        fill_q <= fill_q + FILL_ONE;
      end

      // A write in the previous cycle has already landed in mem_q, so a
      // read right behind it naturally sees the new contents.
      if (svc_rd) begin
        data_q   <= mem_q[req_idx];
        user_q   <= user_mem_q[req_idx];
        rd_cnt_q <= rd_cnt_q + 32'd1;
      end

      // An out-of-range read returns zeros rather than holding stale data.
      if (svc_oor && !bus.we_i) begin
        data_q <= '0;
        user_q <= '0;
      end

      if (svc_wr) begin
        wr_cnt_q <= wr_cnt_q + 32'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Storage write port
  // --------------------------------------------------------------------------
  // NOTE: the storage arrays are deliberately not reset; clearing is the
  // zero-fill sequencer's job, which keeps the arrays mappable onto SRAM.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) begin
          mem_q[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
      // The sideband is only touched when at least one byte is written.
      if (|mem_be) begin
        user_mem_q[mem_idx] <= mem_wuser;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.data_o  = data_q;
  assign bus.user_o  = user_q;
  assign bus.ready_o = ready_q;
  assign bus.oor_o   = oor_q;
  assign rd_cnt_o    = rd_cnt_q;
  assign wr_cnt_o    = wr_cnt_q;

endmodule

// File: tb/tb_axi_mem_sram_bank.sv
// ----------------------------------------------------------------------------
// tb_axi_mem_sram_bank
//   Directed bench for axi_mem_sram_bank configured with 16 x 64-bit words.
//   Inputs are driven on the falling edge; outputs are sampled on the falling
//   edge that follows the rising edge of interest.
// ----------------------------------------------------------------------------
module tb_axi_mem_sram_bank;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned USER_W = 10;
  localparam int unsigned NW     = 16;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] rd_cnt_o;
  logic [31:0] wr_cnt_o;

  axi_mem_sram_bank_if #(
    .ADDR_WIDTH(ADDR_W),
    .DATA_WIDTH(DATA_W),
    .USER_WIDTH(USER_W)
  ) bus ();

  axi_mem_sram_bank #(
    .ADDR_WIDTH(ADDR_W),
    .DATA_WIDTH(DATA_W),
    .USER_WIDTH(USER_W),
    .NUM_WORDS (NW),
    .INIT_ZERO (1'b1)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .bus     (bus),
    .rd_cnt_o(rd_cnt_o),
    .wr_cnt_o(wr_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_rd   = '0;
  logic [31:0] exp_wr   = '0;
  logic [63:0] exp_mem  [NW];
  logic [9:0]  exp_user [NW];

  // Safety net in case the run stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic idle_inputs();
    bus.req_i  = 1'b0;
    bus.we_i   = 1'b0;
    bus.addr_i = '0;
    bus.be_i   = '0;
    bus.data_i = '0;
    bus.user_i = '0;
  endtask

  // Single read, checked against the bench's memory model.
  task automatic rd_check(input logic [63:0] addr, input string name);
    logic [63:0] ed;
    logic [9:0]  eu;
    logic        eo;
    logic [3:0]  idx;
    idx = addr[6:3];
    eo  = (addr >= 64'h80);
    ed  = eo ? 64'h0 : exp_mem[idx];
    eu  = eo ? 10'h0 : exp_user[idx];
    @(negedge clk_i);
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b0;
    bus.addr_i = addr;
    @(negedge clk_i);
    bus.req_i  = 1'b0;
    if (!eo) exp_rd = exp_rd + 32'd1;
    n_checks++;
    if ({bus.data_o, bus.user_o, bus.oor_o} !== {ed, eu, eo}) begin
      n_fail++;
      $display("FAIL %s read data/user/oor: got %h/%h/%b expected %h/%h/%b",
               name, bus.data_o, bus.user_o, bus.oor_o, ed, eu, eo);
    end
    n_checks++;
    if (rd_cnt_o !== exp_rd) begin
      n_fail++;
      $display("FAIL %s rd_cnt: got %0d expected %0d", name, rd_cnt_o, exp_rd);
    end
  endtask

  // Single write; updates the model and checks oor_o and wr_cnt_o.
  task automatic wr_do(input logic [63:0] addr, input logic [7:0] be,
                       input logic [63:0] data, input logic [9:0] user,
                       input string name);
    logic       eo;
    logic [3:0] idx;
    idx = addr[6:3];
    eo  = (addr >= 64'h80);
    @(negedge clk_i);
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b1;
    bus.addr_i = addr;
    bus.be_i   = be;
    bus.data_i = data;
    bus.user_i = user;
    @(negedge clk_i);
    bus.req_i  = 1'b0;
    if (!eo) begin
      exp_wr = exp_wr + 32'd1;
      for (int b = 0; b < 8; b++)
        if (be[b]) exp_mem[idx][8*b +: 8] = data[8*b +: 8];
      if (be != 8'h00) exp_user[idx] = user;
    end
    n_checks++;
    if ({bus.oor_o, wr_cnt_o} !== {eo, exp_wr}) begin
      n_fail++;
      $display("FAIL %s write oor/wr_cnt: got %b/%0d expected %b/%0d",
               name, bus.oor_o, wr_cnt_o, eo, exp_wr);
    end
  endtask

  // Called on a falling edge with rst_i high; releases reset and watches the
  // 16-cycle fill while hammering the bank with requests that must be ignored.
  task automatic fill_check(input string name);
    rst_i      = 1'b0;
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b1;
    bus.be_i   = '1;
    bus.data_i = '1;
    bus.user_i = '1;
    for (int i = 1; i <= 16; i++) begin
      bus.addr_i = (i % 2 == 1) ? 64'h80 : 64'h0;
      @(negedge clk_i);
      n_checks++;
      if (bus.ready_o !== (i >= 16)) begin
        n_fail++;
        $display("FAIL %s ready after %0d cycles: got %b expected %b",
                 name, i, bus.ready_o, (i >= 16));
      end
      n_checks++;
      if ({bus.oor_o, rd_cnt_o, wr_cnt_o} !== {1'b0, 32'd0, 32'd0}) begin
        n_fail++;
        $display("FAIL %s init ignore at cycle %0d: oor=%b rd=%0d wr=%0d expected 0/0/0",
                 name, i, bus.oor_o, rd_cnt_o, wr_cnt_o);
      end
    end
    idle_inputs();
    exp_rd = '0;
    exp_wr = '0;
    for (int w = 0; w < NW; w++) begin
      exp_mem[w]  = '0;
      exp_user[w] = '0;
    end
    for (int w = 0; w < NW; w++) rd_check(64'(w * 8), {name, " zero word"});
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1'b0;
    #1 rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    n_checks++;
    if ({bus.data_o, bus.user_o, bus.ready_o, bus.oor_o, rd_cnt_o, wr_cnt_o} !==
        {64'h0, 10'h0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset values: data=%h user=%h ready=%b oor=%b rd=%0d wr=%0d expected all 0",
               bus.data_o, bus.user_o, bus.ready_o, bus.oor_o, rd_cnt_o, wr_cnt_o);
    end
    fill_check("reset_fill");
  endtask

  task automatic test_write_read();
    wr_do(64'h18, 8'hFF, 64'h1122334455667788, 10'h3, "wr_full");
    rd_check(64'h18, "rd_full");
    n_checks++;
    if ({bus.data_o, bus.user_o, rd_cnt_o, wr_cnt_o} !==
        {64'h1122334455667788, 10'h3, 32'd17, 32'd1}) begin
      n_fail++;
      $display("FAIL full word literal: got %h/%h rd=%0d wr=%0d expected 1122334455667788/003 rd=17 wr=1",
               bus.data_o, bus.user_o, rd_cnt_o, wr_cnt_o);
    end
  endtask

  task automatic test_partial();
    wr_do(64'h18, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 10'h155, "wr_low_half");
    rd_check(64'h18, "rd_low_half");
    n_checks++;
    if ({bus.data_o, bus.user_o} !== {64'h11223344AAAAAAAA, 10'h155}) begin
      n_fail++;
      $display("FAIL partial literal: got %h/%h expected 11223344aaaaaaaa/155",
               bus.data_o, bus.user_o);
    end
    wr_do(64'h18, 8'h00, 64'h0, 10'h2AA, "wr_no_bytes");
    rd_check(64'h18, "rd_no_bytes");
    n_checks++;
    if ({bus.data_o, bus.user_o, wr_cnt_o} !== {64'h11223344AAAAAAAA, 10'h155, 32'd3}) begin
      n_fail++;
      $display("FAIL be0 literal: got %h/%h wr=%0d expected 11223344aaaaaaaa/155 wr=3",
               bus.data_o, bus.user_o, wr_cnt_o);
    end
    // Byte-offset bits are ignored: 0x1F addresses the same word as 0x18.
    rd_check(64'h1F, "rd_unaligned");
  endtask

  task automatic test_oor();
    wr_do(64'h78, 8'hFF, 64'hFEDCBA9876543210, 10'h3FF, "wr_last_word");
    rd_check(64'h78, "rd_last_word");
    rd_check(64'h80, "rd_oor");
    @(negedge clk_i);
    n_checks++;
    if ({bus.oor_o, bus.data_o, bus.user_o} !== {1'b0, 64'h0, 10'h0}) begin
      n_fail++;
      $display("FAIL oor pulse width: oor=%b data=%h user=%h expected 0/0/0",
               bus.oor_o, bus.data_o, bus.user_o);
    end
    wr_do(64'h80, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 10'h3FF, "wr_oor");
    rd_check(64'h8000000000000018, "rd_oor_high");
    for (int w = 0; w < NW; w++) rd_check(64'(w * 8), "oor_scan");
  endtask

  task automatic test_back_to_back();
    logic [63:0] d [4];
    logic [63:0] held;
    d[0] = 64'hA0A1A2A3A4A5A6A7;
    d[1] = 64'hB0B1B2B3B4B5B6B7;
    d[2] = 64'hC0C1C2C3C4C5C6C7;
    d[3] = 64'hD0D1D2D3D4D5D6D7;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      bus.req_i  = 1'b1;
      bus.we_i   = 1'b1;
      bus.addr_i = 64'(i * 8);
      bus.be_i   = 8'hFF;
      bus.data_i = d[i];
      bus.user_i = 10'(i + 16);
      exp_mem[i]  = d[i];
      exp_user[i] = 10'(i + 16);
      exp_wr = exp_wr + 32'd1;
    end
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk_i);
      if (i < 4) begin
        bus.req_i  = 1'b1;
        bus.we_i   = 1'b0;
        bus.addr_i = 64'(i * 8);
      end else begin
        bus.req_i = 1'b0;
      end
      if (i > 0) begin
        n_checks++;
        if ({bus.data_o, bus.user_o} !== {d[i-1], 10'(i + 15)}) begin
          n_fail++;
          $display("FAIL b2b read %0d: got %h/%h expected %h/%h",
                   i - 1, bus.data_o, bus.user_o, d[i-1], 10'(i + 15));
        end
      end
      if (i < 4) exp_rd = exp_rd + 32'd1;
    end
    n_checks++;
    if ({rd_cnt_o, wr_cnt_o} !== {exp_rd, exp_wr}) begin
      n_fail++;
      $display("FAIL b2b counters: rd=%0d wr=%0d expected rd=%0d wr=%0d",
               rd_cnt_o, wr_cnt_o, exp_rd, exp_wr);
    end
    // Write then read the same word on the very next cycle.
    held = bus.data_o;
    @(negedge clk_i);
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b1;
    bus.addr_i = 64'h8;
    bus.be_i   = 8'hFF;
    bus.data_i = 64'hDEADBEEF0BADF00D;
    bus.user_i = 10'h2A5;
    exp_mem[1]  = 64'hDEADBEEF0BADF00D;
    exp_user[1] = 10'h2A5;
    exp_wr = exp_wr + 32'd1;
    @(negedge clk_i);
    n_checks++;
    if (bus.data_o !== held) begin
      n_fail++;
      $display("FAIL hold during write: got %h expected %h", bus.data_o, held);
    end
    bus.we_i = 1'b0;
    exp_rd = exp_rd + 32'd1;
    @(negedge clk_i);
    bus.req_i = 1'b0;
    n_checks++;
    if ({bus.data_o, bus.user_o, rd_cnt_o, wr_cnt_o} !==
        {64'hDEADBEEF0BADF00D, 10'h2A5, exp_rd, exp_wr}) begin
      n_fail++;
      $display("FAIL read after write: got %h/%h rd=%0d wr=%0d expected deadbeef0badf00d/2a5 rd=%0d wr=%0d",
               bus.data_o, bus.user_o, rd_cnt_o, wr_cnt_o, exp_rd, exp_wr);
    end
  endtask

  task automatic test_reset_mid_fill();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (5) @(negedge clk_i);
    // fill_q is 5 here; assert reset asynchronously in mid-cycle.
    #2 rst_i = 1'b1;
    #1;
    n_checks++;
    if ({bus.ready_o, bus.data_o, rd_cnt_o, wr_cnt_o} !== {1'b0, 64'h0, 32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL async reset mid-fill: ready=%b data=%h rd=%0d wr=%0d expected 0",
               bus.ready_o, bus.data_o, rd_cnt_o, wr_cnt_o);
    end
    @(negedge clk_i);
    fill_check("refill");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial();
    test_oor();
    test_back_to_back();
    test_reset_mid_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
